lsu: RTL and testbench
======================

Name: lsu

Overview:
- Memory stage of the riscvBoy core, between the EX/MEM pipeline register and the writeback stage.
- Issues RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) on a req/gnt + rvalid data bus.
- Aligns and sign/zero-extends load data; stalls the pipeline while an access is outstanding.
- Presents a registered result bundle to writeback: mux select, rd write enable, rd address, ALU result, memory data.

Parameters:
- DATA_WIDTH, 32, datapath and bus data width (only 32 supported).
- ADDR_WIDTH, 32, bus address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  instruction present from EX
- i_mem_ren  in  1  instruction is a load
- i_mem_wen  in  1  instruction is a store
- i_funct3  in  3  RV32I width/sign code
- i_alu_result  in  DATA_WIDTH  effective address, or ALU result for non-memory instructions
- i_store_data  in  DATA_WIDTH  rs2 value
- i_rd_wen  in  1  rd write enable
- i_rd_addr  in  5  destination register
- o_stall  out  1  freeze upstream stages and hold inputs stable
- o_bus_req  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  DATA_WIDTH  lane-shifted store data
- i_bus_gnt  in  1  request accepted
- i_bus_rvalid  in  1  read data valid
- i_bus_rdata  in  DATA_WIDTH  read data
- o_misaligned  out  1  one-cycle pulse on a misaligned access
- o_sel  out  1  writeback mux select (0 = ALU result, 1 = memory data)
- o_rd_wen  out  1  to writeback
- o_rd_addr  out  5  to writeback
- o_alu_result  out  DATA_WIDTH  to writeback
- o_mem_data  out  DATA_WIDTH  to writeback

Behaviour:
- Reset: FSM enters IDLE; every output register is 0. o_stall, o_bus_req and o_misaligned are 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - i_valid and no memory op: on the next edge, o_rd_wen ← i_rd_wen, o_rd_addr ← i_rd_addr, o_alu_result ← i_alu_result, o_sel ← 0. Latency 1.
  - i_valid and a memory op (i_mem_ren takes priority if both are set), aligned: latch address, funct3, byte enables, wdata and rd fields; go to REQ. o_rd_wen ← 0 (bubble).
  - Misaligned (halfword with addr[0]=1, or word with addr[1:0]≠0): no bus access, o_misaligned pulses 1 cycle, o_rd_wen ← 0, stay IDLE.
  - i_valid = 0: o_rd_wen ← 0.
- REQ:
  - o_bus_req = 1; address, we, be and wdata are held stable until i_bus_gnt is sampled 1.
  - On gnt, a store goes to IDLE and the writeback bundle is a bubble (o_rd_wen ← 0).
  - On gnt, a load goes to RESP.
- RESP:
  - Wait for i_bus_rvalid. i_bus_rvalid outside RESP is ignored.
  - On rvalid: select byte/half by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Then o_mem_data ← extended value, o_sel ← 1, o_rd_wen ← latched rd_wen, o_rd_addr ← latched rd; go to IDLE.
- o_stall = (state ≠ IDLE) or (IDLE and i_valid and aligned memory op). It drops in the same cycle the FSM returns to IDLE.
  - Minimum load latency: 3 cycles (accept, gnt, rvalid). Minimum store latency: 2 cycles.
- Byte enables and store lanes:
  - SB: be = 0001 << addr[1:0], with the byte replicated to all 4 lanes.
  - SH: be = 0011 << addr[1:0], with the half replicated to both halves.
  - SW: be = 1111.
- Simultaneous events:
  - gnt and rvalid in the same cycle while in REQ: rvalid is ignored (the bus must not do this).
  - gnt asserted while o_bus_req = 0: ignored.
- Reset mid-operation: FSM returns to IDLE at once, the request drops asynchronously, and any later rvalid is ignored.
- Undefined funct3 encodings (011, 110, 111) on a memory op are treated as LW/SW.

Decomposition:
- Shared core package, pkg_core: funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101) and the state encoding localparams.
- One sub-module, lsu_load_align: purely combinational. Inputs rdata, addr[1:0], funct3; output is the extended value. Reused by any future cache path.

Test Plan:
- Non-memory op: ALU result 0x1234_5678, rd=5, rd_wen=1 → next cycle o_sel=0, o_alu_result=0x1234_5678, o_rd_addr=5, o_rd_wen=1, o_stall never 1.
- LB at address 0x103, rdata=0x80AA_BBCC, gnt 2 cycles late → o_bus_addr=0x100, o_mem_data=0xFFFF_FF80, o_sel=1, o_stall high throughout.
- LHU at 0x102, rdata=0x8001_0000 → o_mem_data=0x0000_8001. LW at 0x0, rdata=0xDEAD_BEEF → o_mem_data=0xDEAD_BEEF.
- SB 0xA5 at 0x201 → o_bus_be=0010, o_bus_wdata=0xA5A5_A5A5, o_bus_we=1, completes on gnt, o_rd_wen=0. SH 0xBEEF at 0x202 → o_bus_be=1100.
- LW at 0x102 → o_misaligned 1-cycle pulse, o_bus_req stays 0, o_rd_wen=0, FSM remains IDLE.
- Assert rst_n=0 while in RESP → o_bus_req, o_stall, o_rd_wen drop to 0 at once; a later rvalid produces no writeback.

Source files
------------

// File: rtl/pkg_core.sv
// Shared core definitions: RV32I load/store width codes and the memory-stage state encoding.
package pkg_core;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ST_IDLE_ENC = 2'b00;
    localparam logic [1:0] ST_REQ_ENC  = 2'b01;
    localparam logic [1:0] ST_RESP_ENC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_REQ  = ST_REQ_ENC,
        ST_RESP = ST_RESP_ENC
    } lsu_state_e;

    // funct3[1:0] carries the access size; the undefined codes 011/110/111 fall into the word case.
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addrLo[0];
            default: mis = (addrLo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module lsu_load_align
    import pkg_core::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        signExt;

    always_comb begin
        case (addr_i)
            2'd0:    byteSel = rdata_i[7:0];
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            default: byteSel = rdata_i[31:24];
        endcase
        halfSel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        // funct3[2] set means the unsigned variant (LBU/LHU)
        signExt = ~funct3_i[2];
        case (funct3_i[1:0])
            2'b00:   data_o = {{24{signExt & byteSel[7]}}, byteSel};
            2'b01:   data_o = {{16{signExt & halfSel[15]}}, halfSel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Memory stage: issues loads/stores on a req/gnt + rvalid bus, stalls while busy,
// and registers the writeback bundle.
module lsu
    import pkg_core::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic                  i_mem_ren,
    input  logic                  i_mem_wen,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    input  logic                  i_rd_wen,
    input  logic [4:0]            i_rd_addr,
    output logic                  o_stall,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [3:0]            o_bus_be,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_gnt,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    output logic                  o_misaligned,
    output logic                  o_sel,
    output logic                  o_rd_wen,
    output logic [4:0]            o_rd_addr,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_mem_data
);

    lsu_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rdWenLat_q;
    logic [4:0]            rdAddrLat_q;
    logic                  misaligned_q;
    logic                  sel_q;
    logic                  rdWen_q;
    logic [4:0]            rdAddr_q;
    logic [DATA_WIDTH-1:0] alu_q;
    logic [DATA_WIDTH-1:0] memData_q;

    logic                  memOp;
    logic                  misaligned;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] loadData;

    assign memOp      = i_mem_ren | i_mem_wen;
    assign misaligned = isMisaligned(i_funct3, i_alu_result[1:0]);

    // Sub-word stores replicate the data across lanes; the byte enables pick the live lane.
    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << i_alu_result[1:0];
                wdata_d = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << i_alu_result[1:0];
                wdata_d = {2{i_store_data[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = i_store_data;
            end
        endcase
    end

    lsu_load_align u_align (
        .rdata_i  (i_bus_rdata),
        .addr_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (loadData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            rdWenLat_q   <= 1'b0;
            rdAddrLat_q  <= '0;
            misaligned_q <= 1'b0;
            sel_q        <= 1'b0;
            rdWen_q      <= 1'b0;
            rdAddr_q     <= '0;
            alu_q        <= '0;
            memData_q    <= '0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rdWen_q <= 1'b0;
                    if (i_valid && memOp && misaligned) begin
                        misaligned_q <= 1'b1;
                    end else if (i_valid && memOp) begin
                        addr_q      <= i_alu_result[ADDR_WIDTH-1:0];
                        funct3_q    <= i_funct3;
                        we_q        <= ~i_mem_ren;
                        be_q        <= be_d;
                        wdata_q     <= wdata_d;
                        rdWenLat_q  <= i_rd_wen;
                        rdAddrLat_q <= i_rd_addr;
                        state_q     <= ST_REQ;
                    end else if (i_valid) begin
                        rdWen_q  <= i_rd_wen;
                        rdAddr_q <= i_rd_addr;
                        alu_q    <= i_alu_result;
                        sel_q    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (i_bus_gnt) begin
                        state_q <= we_q ? ST_IDLE : ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_bus_rvalid) begin
                        memData_q <= loadData;
                        sel_q     <= 1'b1;
                        rdWen_q   <= rdWenLat_q;
                        rdAddr_q  <= rdAddrLat_q;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_stall      = (state_q != ST_IDLE) || (i_valid && memOp && !misaligned);
    assign o_bus_req    = (state_q == ST_REQ);
    assign o_bus_we     = we_q;
    assign o_bus_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign o_bus_be     = be_q;
    assign o_bus_wdata  = wdata_q;
    assign o_misaligned = misaligned_q;
    assign o_sel        = sel_q;
    assign o_rd_wen     = rdWen_q;
    assign o_rd_addr    = rdAddr_q;
    assign o_alu_result = alu_q;
    assign o_mem_data   = memData_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for the memory stage: expected writebacks are queued at issue
// and compared whenever the stage raises o_rd_wen.
module tb_lsu;

    typedef struct {
        logic        sel;
        logic [4:0]  rd;
        logic [31:0] data;
    } wbExp_t;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_mem_ren;
    logic        i_mem_wen;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic        i_rd_wen;
    logic [4:0]  i_rd_addr;
    logic        o_stall;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_gnt;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        o_misaligned;
    logic        o_sel;
    logic        o_rd_wen;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_alu_result;
    logic [31:0] o_mem_data;

    wbExp_t sbQ[$];
    wbExp_t popped;
    int     compareCount = 0;
    int     failCount = 0;

    lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .i_mem_ren    (i_mem_ren),
        .i_mem_wen    (i_mem_wen),
        .i_funct3     (i_funct3),
        .i_alu_result (i_alu_result),
        .i_store_data (i_store_data),
        .i_rd_wen     (i_rd_wen),
        .i_rd_addr    (i_rd_addr),
        .o_stall      (o_stall),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_be     (o_bus_be),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_gnt    (i_bus_gnt),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata),
        .o_misaligned (o_misaligned),
        .o_sel        (o_sel),
        .o_rd_wen     (o_rd_wen),
        .o_rd_addr    (o_rd_addr),
        .o_alu_result (o_alu_result),
        .o_mem_data   (o_mem_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Writeback monitor: every o_rd_wen pulse must match the oldest queued entry.
    always @(negedge clk) begin
        if (o_rd_wen) begin
            if (sbQ.size() == 0) begin
                checkOutput("wbUnexpected", 32'd1, 32'd0);
            end else begin
                popped = sbQ.pop_front();
                checkOutput("wbSel", {31'd0, o_sel}, {31'd0, popped.sel});
                checkOutput("wbRd", {27'd0, o_rd_addr}, {27'd0, popped.rd});
                if (popped.sel) checkOutput("wbMem", o_mem_data, popped.data);
                else            checkOutput("wbAlu", o_alu_result, popped.data);
            end
        end
    end

    task automatic clearInputs();
        i_valid   = 1'b0;
        i_mem_ren = 1'b0;
        i_mem_wen = 1'b0;
        i_rd_wen  = 1'b0;
    endtask

    task automatic applyAlu(input logic [31:0] alu, input logic [4:0] rd);
        @(posedge clk); #1;
        i_valid = 1'b1; i_mem_ren = 1'b0; i_mem_wen = 1'b0;
        i_alu_result = alu; i_rd_addr = rd; i_rd_wen = 1'b1; i_funct3 = 3'b000;
        sbQ.push_back('{sel: 1'b0, rd: rd, data: alu});
        #2 checkOutput("aluStall", {31'd0, o_stall}, 32'd0);
        @(posedge clk); #1;
        clearInputs();
        checkOutput("aluResult", o_alu_result, alu);
        checkOutput("aluStallAfter", {31'd0, o_stall}, 32'd0);
    endtask

    // One load or store through the bus with a configurable grant delay.
    task automatic applyStimulus(input string name, input logic isStore, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata, input int gntDelay,
                                 input logic [31:0] rdata, input logic [3:0] expBe,
                                 input logic [31:0] expWdata, input logic [31:0] expMem, input logic [4:0] rd);
        @(posedge clk); #1;
        i_valid = 1'b1; i_mem_ren = !isStore; i_mem_wen = isStore;
        i_funct3 = f3; i_alu_result = addr; i_store_data = sdata;
        i_rd_wen = !isStore; i_rd_addr = rd;
        if (!isStore) sbQ.push_back('{sel: 1'b1, rd: rd, data: expMem});
        #2 checkOutput({name, "_stallAccept"}, {31'd0, o_stall}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < gntDelay; i++) begin
            checkOutput({name, "_reqWait"}, {31'd0, o_bus_req}, 32'd1);
            checkOutput({name, "_stallWait"}, {31'd0, o_stall}, 32'd1);
            @(posedge clk); #1;
        end
        checkOutput({name, "_req"}, {31'd0, o_bus_req}, 32'd1);
        checkOutput({name, "_addr"}, o_bus_addr, {addr[31:2], 2'b00});
        checkOutput({name, "_we"}, {31'd0, o_bus_we}, {31'd0, isStore});
        if (isStore) begin
            checkOutput({name, "_be"}, {28'd0, o_bus_be}, {28'd0, expBe});
            checkOutput({name, "_wdata"}, o_bus_wdata, expWdata);
        end
        i_bus_gnt = 1'b1;
        @(posedge clk); #1;
        i_bus_gnt = 1'b0;
        if (isStore) begin
            clearInputs();
            #1;
            checkOutput({name, "_stallDone"}, {31'd0, o_stall}, 32'd0);
            checkOutput({name, "_rdWen"}, {31'd0, o_rd_wen}, 32'd0);
        end else begin
            checkOutput({name, "_stallResp"}, {31'd0, o_stall}, 32'd1);
            checkOutput({name, "_reqResp"}, {31'd0, o_bus_req}, 32'd0);
            i_bus_rvalid = 1'b1; i_bus_rdata = rdata;
            @(posedge clk); #1;
            i_bus_rvalid = 1'b0;
            clearInputs();
            #1;
            checkOutput({name, "_stallDone"}, {31'd0, o_stall}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clearInputs();
        i_funct3 = '0; i_alu_result = '0; i_store_data = '0; i_rd_addr = '0;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
        #12;
        checkOutput("rstStall", {31'd0, o_stall}, 32'd0);
        checkOutput("rstReq", {31'd0, o_bus_req}, 32'd0);
        checkOutput("rstMis", {31'd0, o_misaligned}, 32'd0);
        checkOutput("rstRdWen", {31'd0, o_rd_wen}, 32'd0);
        checkOutput("rstAlu", o_alu_result, 32'd0);
        checkOutput("rstMem", o_mem_data, 32'd0);
        rst_n = 1'b1;

        applyAlu(32'h1234_5678, 5'd5);
        //              name     st    f3      addr          sdata         gnt rdata         be       wdata         mem           rd
        applyStimulus("lb",    1'b0, 3'b000, 32'h0000_0103, 32'h0,        2, 32'h80AA_BBCC, 4'b0000, 32'h0,        32'hFFFF_FF80, 5'd1);
        applyStimulus("lhu",   1'b0, 3'b101, 32'h0000_0102, 32'h0,        0, 32'h8001_0000, 4'b0000, 32'h0,        32'h0000_8001, 5'd2);
        applyStimulus("lw",    1'b0, 3'b010, 32'h0000_0000, 32'h0,        1, 32'hDEAD_BEEF, 4'b0000, 32'h0,        32'hDEAD_BEEF, 5'd3);
        applyStimulus("lh",    1'b0, 3'b001, 32'h0000_0002, 32'h0,        0, 32'h8001_0000, 4'b0000, 32'h0,        32'hFFFF_8001, 5'd4);
        applyStimulus("lbu",   1'b0, 3'b100, 32'h0000_0011, 32'h0,        0, 32'h0000_F000, 4'b0000, 32'h0,        32'h0000_00F0, 5'd6);
        applyStimulus("sb",    1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 1, 32'h0,        4'b0010, 32'hA5A5_A5A5, 32'h0,        5'd7);
        applyStimulus("sh",    1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0,        5'd8);
        applyStimulus("sw",    1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 3, 32'h0,        4'b1111, 32'hCAFE_F00D, 32'h0,        5'd9);
        applyAlu(32'h0BAD_F00D, 5'd31);

        // Misaligned word load: pulse only, no bus activity, no writeback.
        @(posedge clk); #1;
        i_valid = 1'b1; i_mem_ren = 1'b1; i_funct3 = 3'b010; i_alu_result = 32'h0000_0102;
        i_rd_wen = 1'b1; i_rd_addr = 5'd12;
        #2 checkOutput("misStall", {31'd0, o_stall}, 32'd0);
        @(posedge clk); #1;
        clearInputs();
        checkOutput("misPulse", {31'd0, o_misaligned}, 32'd1);
        checkOutput("misReq", {31'd0, o_bus_req}, 32'd0);
        @(posedge clk); #1;
        checkOutput("misPulseEnd", {31'd0, o_misaligned}, 32'd0);
        checkOutput("misIdleReq", {31'd0, o_bus_req}, 32'd0);

        // A grant with no request outstanding must be ignored.
        i_bus_gnt = 1'b1;
        @(posedge clk); #1;
        i_bus_gnt = 1'b0;
        checkOutput("strayGntReq", {31'd0, o_bus_req}, 32'd0);
        checkOutput("strayGntStall", {31'd0, o_stall}, 32'd0);

        // Reset while waiting for read data: everything drops, late rvalid is ignored.
        @(posedge clk); #1;
        i_valid = 1'b1; i_mem_ren = 1'b1; i_funct3 = 3'b010; i_alu_result = 32'h0000_0040;
        i_rd_wen = 1'b1; i_rd_addr = 5'd13;
        @(posedge clk); #1;
        i_bus_gnt = 1'b1;
        @(posedge clk); #1;
        i_bus_gnt = 1'b0;
        checkOutput("rstRespStallBefore", {31'd0, o_stall}, 32'd1);
        #2;
        rst_n = 1'b0;
        clearInputs();
        #1;
        checkOutput("rstRespReq", {31'd0, o_bus_req}, 32'd0);
        checkOutput("rstRespStall", {31'd0, o_stall}, 32'd0);
        checkOutput("rstRespRdWen", {31'd0, o_rd_wen}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        i_bus_rvalid = 1'b0;
        checkOutput("lateRvalidRdWen", {31'd0, o_rd_wen}, 32'd0);
        checkOutput("lateRvalidStall", {31'd0, o_stall}, 32'd0);

        @(posedge clk); #1;
        checkOutput("sbEmpty", sbQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
